// File: rtl/spi_readback_if.sv
// spi_readback_if: host SPI pins, the register bank being read back and the
// status outputs of spi_readback, grouped for a single module port.
interface spi_readback_if;
  logic        spi_en;
  logic        spi_clk;
  logic        spi_mosi;
  logic [63:0] reg_data;
  logic        spi_miso;
  logic        spi_miso_oe;
  logic        busy;
  logic        rd_done;
  logic        frame_err;

  modport slave (
    input  spi_en, spi_clk, spi_mosi, reg_data,
    output spi_miso, spi_miso_oe, busy, rd_done, frame_err
  );

  modport master (
    output spi_en, spi_clk, spi_mosi, reg_data,
    input  spi_miso, spi_miso_oe, busy, rd_done, frame_err
  );
endinterface

// File: rtl/spi_readback.sv
// spi_readback: oversampled SPI slave returning one byte of an 8x8 register bank.
// Define SPI_RB_PARITY_EN to append an odd-parity bit to every read.
module spi_readback (
  input  logic          clk,
  input  logic          rst,
  spi_readback_if.slave bus
);

`ifdef SPI_RB_PARITY_EN
  localparam int unsigned SH_W = 9;
`else
  localparam int unsigned SH_W = 8;
`endif

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CMD  = 3'd1,
    S_DATA = 3'd2,
    S_SKIP = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_en_s1, r_en_s2, r_en_s3;
  logic            r_sck_s1, r_sck_s2, r_sck_s3;
  logic            r_mosi_s1, r_mosi_s2;
  logic [1:0]      r_sync_vld;
  logic            r_armed;
  logic            w_en_rise, w_en_fall, w_sck_rise, w_sck_fall;
  logic [2:0]      r_cnt;
  logic [7:0]      r_cmd;
  logic            r_cmd_full;
  logic [SH_W-1:0] r_shadow;
  logic [SH_W-1:0] w_load;
  logic [7:0]      w_sel;
  logic            w_last;
  logic            w_busy, w_oe, w_miso;
  logic            w_rd_done_nxt, w_frame_err_nxt;
  logic            r_rd_done, r_frame_err;

  // An spi_en already high when reset releases must not start a frame, so
  // rising edges count only once the synchronized level has been seen low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {r_en_s1, r_en_s2, r_en_s3}    <= 3'b000;
      {r_sck_s1, r_sck_s2, r_sck_s3} <= 3'b000;
      {r_mosi_s1, r_mosi_s2}         <= 2'b00;
      r_sync_vld                     <= 2'b00;
      r_armed                        <= 1'b0;
    end else begin
      {r_en_s1, r_en_s2, r_en_s3}    <= {bus.spi_en, r_en_s1, r_en_s2};
      {r_sck_s1, r_sck_s2, r_sck_s3} <= {bus.spi_clk, r_sck_s1, r_sck_s2};
      {r_mosi_s1, r_mosi_s2}         <= {bus.spi_mosi, r_mosi_s1};
      r_sync_vld                     <= {r_sync_vld[0], 1'b1};
      r_armed                        <= r_armed | (r_sync_vld[1] & ~r_en_s2);
    end
  end

  assign w_en_rise  = r_en_s2 & ~r_en_s3 & r_armed;
  assign w_en_fall  = ~r_en_s2 & r_en_s3;
  assign w_sck_rise = r_sck_s2 & ~r_sck_s3;
  assign w_sck_fall = ~r_sck_s2 & r_sck_s3;
  assign w_sel      = bus.reg_data[{r_cmd[2:0], 3'b000} +: 8];

`ifdef SPI_RB_PARITY_EN
  logic r_tail;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  assign w_load = {w_sel, odd_parity(w_sel)};
  assign w_last = r_tail;

  // Marks that the eight data bits are out and the parity bit is on the line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tail <= 1'b0;
    end else if (r_state == S_IDLE) begin
      r_tail <= 1'b0;
    end else if ((r_state == S_DATA) && w_sck_fall && (r_cnt == 3'd7)) begin
      r_tail <= 1'b1;
    end
  end
`else
  assign w_load = w_sel;
  assign w_last = (r_cnt == 3'd7);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // The command is decoded one cycle after its 8th bit so every bit of r_cmd is registered first.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_en_rise) w_next = S_CMD;
        else           w_next = S_IDLE;
      end
      S_CMD: begin
        if (w_en_fall)       w_next = S_IDLE;
        else if (r_cmd_full) w_next = r_cmd[7] ? S_DATA : S_SKIP;
        else                 w_next = S_CMD;
      end
      S_DATA: begin
        if (w_en_fall)                w_next = S_IDLE;
        else if (w_sck_fall && w_last) w_next = S_DONE;
        else                          w_next = S_DATA;
      end
      S_SKIP, S_DONE: begin
        if (!r_en_s2) w_next = S_IDLE;
        else          w_next = r_state;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy          = (r_state != S_IDLE);
    w_oe            = (r_state == S_DATA);
    w_miso          = w_oe & r_shadow[SH_W-1];
    w_rd_done_nxt   = (r_state == S_DATA) && (w_next == S_DONE);
    w_frame_err_nxt = ((r_state == S_CMD) || (r_state == S_DATA)) && w_en_fall;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_done   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_rd_done   <= w_rd_done_nxt;
      r_frame_err <= w_frame_err_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt      <= 3'd0;
      r_cmd      <= 8'd0;
      r_cmd_full <= 1'b0;
      r_shadow   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_en_rise) begin
            r_cnt      <= 3'd0;
            r_cmd      <= 8'd0;
            r_cmd_full <= 1'b0;
          end
        end
        S_CMD: begin
          if (r_cmd_full) begin
            r_shadow   <= w_load;
            r_cmd_full <= 1'b0;
          end else if (w_sck_rise) begin
            r_cmd      <= {r_cmd[6:0], r_mosi_s2};
            r_cnt      <= r_cnt + 3'd1;
            r_cmd_full <= (r_cnt == 3'd7);
          end
        end
        S_DATA: begin
          if (w_sck_fall) begin
            r_shadow <= {r_shadow[SH_W-2:0], 1'b0};
            r_cnt    <= r_cnt + 3'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.spi_miso    = w_miso;
  assign bus.spi_miso_oe = w_oe;
  assign bus.busy        = w_busy;
  assign bus.rd_done     = r_rd_done;
  assign bus.frame_err   = r_frame_err;

endmodule
